uc_microc: RTL
==============

Name: uc_microc

Overview:
- Control unit that sits directly upstream of the microc datapath. It consumes the datapath's Opcode and z flag and drives its control inputs (s_inc, s_inm, we3, wez, Op).
- Adds a small sequencer for start-up, multi-cycle WAIT and HALT.
- Adds one new datapath input, pc_we (PC register write enable), which the datapath gains alongside this block.
- Single-cycle datapath: control outputs are combinational from (state, Opcode, z). Only sequencing state and the wait counter are registered.

Parameters:
- START_CYCLES, 1, idle cycles after reset release before the first instruction commits (range 1..3).
- WAIT_W, 2, width of the WAIT count field taken from Opcode[WAIT_W-1:0] (range 1..4).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Opcode  in  6  instruction opcode from the datapath (instr[15:10]).
- z  in  1  registered zero flag from the datapath.
- s_inc  out  1  PC mux select: 1 = PC+1, 0 = jump address.
- s_inm  out  1  register-file write-data select: 1 = immediate, 0 = ALU result.
- we3  out  1  register-file write enable.
- wez  out  1  zero-flag write enable.
- Op  out  3  ALU operation.
- pc_we  out  1  PC update enable.
- halted  out  1  high while in HALT.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset. Reset forces state=START and the start counter and wait counter to 0.
- Outputs in START, WAIT and HALT:
  - s_inc=0, s_inm=0, we3=0, wez=0, Op=000, pc_we=0.
  - halted=1 only in HALT.
  - These are also the output values while reset is high.
- START: stays for START_CYCLES rising edges after reset deasserts, then goes to RUN.
- RUN decode (pc_we=1 unless stated; unlisted outputs are 0):
  - 1oooxx (ALU): Op=Opcode[4:2], s_inc=1, s_inm=0, we3=1, wez=1.
  - 0000xx (LI): s_inc=1, s_inm=1, we3=1, Op=000.
  - 0001xx (J): s_inc=0.
  - 0010xx (JZ): s_inc=~z.
  - 0011xx (JNZ): s_inc=z.
  - 0100xx (NOP): s_inc=1.
  - 0101nn (WAIT): pc_we=0, all writes 0. Counter loads n=Opcode[WAIT_W-1:0]. Next state is WAIT.
  - 0111xx (HALT): pc_we=0. Next state is HALT.
  - 0110xx (reserved): treated as NOP.
- WAIT:
  - If counter != 0: hold, decrement by 1.
  - If counter == 0: assert s_inc=1, pc_we=1 this cycle, return to RUN.
  - Total WAIT instruction latency is n+2 cycles (decode cycle, n hold cycles, release cycle).
  - No register, flag or memory writes occur during WAIT.
- HALT: absorbing. Only reset exits. Opcode and z are ignored.
- Branch evaluation uses the current z. A flag written by the previous ALU instruction is visible to the JZ/JNZ that follows it.
- Opcode changes during WAIT or HALT are ignored; the counter is not reloaded.
- Reset asserted mid-WAIT or in HALT returns immediately (asynchronously) to START with all outputs at reset values.
- No X propagation: default every output before case decode.

Test Plan:
- Reset release, START_CYCLES=1, Opcode=000000 -> first edge pc_we=0. Next cycle s_inc=1, s_inm=1, we3=1, wez=0, pc_we=1.
- Opcode=101000 (ALU, Op=010) then 101100 (Op=011) -> Op=010 then 011, each with we3=1, wez=1, s_inc=1, s_inm=0.
- JZ (001000) with z=1 -> s_inc=0. With z=0 -> s_inc=1. JNZ (001100) gives the inverse. pc_we=1 in all four cases.
- WAIT 010111 (n=3) -> pc_we=0 for 4 cycles, then one cycle s_inc=1, pc_we=1, back to RUN. Total 5 cycles. Writes stay 0 throughout.
- HALT 011100 -> halted=1, pc_we=0 indefinitely while Opcode toggles. Reset pulse -> halted=0, START, then RUN.
- Reset asserted mid-WAIT (counter=2), asynchronous between edges -> outputs go to zero immediately. After release, 1 START cycle then RUN decode of the current Opcode.

Source files
------------

// File: rtl/uc_microc.sv
// uc_microc: control unit and start/WAIT/HALT sequencer for the microc datapath.
// Latency: decode is combinational from (state, Opcode, z); WAIT takes n+2 cycles; HALT stalls the PC until reset.
module uc_microc #(
  parameter int START_CYCLES = 1,
  parameter int WAIT_W       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       z,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we3,
  output logic       wez,
  output logic [2:0] Op,
  output logic       pc_we,
  output logic       halted
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] START_LAST = 2'(START_CYCLES - 1);

  state_t            state, state_nxt;
  logic [1:0]        start_cnt, start_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_START;
      start_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      start_cnt <= start_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    start_cnt_nxt = start_cnt;
    wait_cnt_nxt  = wait_cnt;
    s_inc         = 1'b0;
    s_inm         = 1'b0;
    we3           = 1'b0;
    wez           = 1'b0;
    Op            = 3'b000;
    pc_we         = 1'b0;
    halted        = 1'b0;

    case (state)
      ST_START: begin
        if (start_cnt == START_LAST) state_nxt = ST_RUN;
        else                         start_cnt_nxt = start_cnt + 2'd1;
      end

      ST_RUN: begin
        if (Opcode[5]) begin
          Op    = Opcode[4:2];
          s_inc = 1'b1;
          we3   = 1'b1;
          wez   = 1'b1;
          pc_we = 1'b1;
        end else begin
          case (Opcode[4:2])
            3'b000: begin
              s_inc = 1'b1;
              s_inm = 1'b1;
              we3   = 1'b1;
              pc_we = 1'b1;
            end
            3'b001: pc_we = 1'b1;
            3'b010: begin
              s_inc = ~z;
              pc_we = 1'b1;
            end
            3'b011: begin
              s_inc = z;
              pc_we = 1'b1;
            end
            3'b101: begin
              wait_cnt_nxt = Opcode[WAIT_W-1:0];
              state_nxt    = ST_WAIT;
            end
            3'b111: state_nxt = ST_HALT;
            // 100 (NOP) and reserved 110 both just advance the PC
            default: begin
              s_inc = 1'b1;
              pc_we = 1'b1;
            end
          endcase
        end
      end

      ST_WAIT: begin
        if (wait_cnt != '0) begin
          wait_cnt_nxt = wait_cnt - WAIT_W'(1);
        end else begin
          s_inc     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = ST_RUN;
        end
      end

      ST_HALT: halted = 1'b1;

      default: state_nxt = ST_START;
    endcase
  end

endmodule
